// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state encoding and constants for the fetch stage.
package instr_fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} fetch_state_e;
    localparam logic [31:0] NOP              = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry skid register holding a returned word while IF/ID is stalled.
module fetch_skid
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] dout
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= NOP;
        end else if (clear) begin
            valid <= 1'b0;
            dout  <= NOP;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding request FSM and IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [5:0]  opcode
);
    fetch_state_e state, state_n;
    logic [31:0] pc, pc_n, load_data, skid_data, target;
    logic        squash, squash_n, load, skid_load, skid_clear, skid_valid, if_free;

    assign target      = {redirect_pc[31:2], 2'b00};
    assign imem_req    = (state == FETCH) && !redirect_valid;
    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign opcode      = if_instr[31:26];
    assign if_free     = !if_valid || !stall;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        squash_n   = squash;
        load       = 1'b0;
        load_data  = imem_rdata;
        skid_load  = 1'b0;
        skid_clear = redirect_valid;
        case (state)
            IDLE:  state_n = FETCH;
            FETCH: begin
                if (redirect_valid) pc_n = target;
                else if (imem_gnt) state_n = WAIT;
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_n     = target;
                    squash_n = !imem_rvalid;
                    state_n  = imem_rvalid ? FETCH : WAIT;
                end else if (imem_rvalid) begin
                    // A squashed response or a free IF/ID both free the request slot
                    squash_n  = 1'b0;
                    load      = !squash && if_free;
                    skid_load = !squash && !if_free;
                    pc_n      = load ? pc + 32'd4 : pc;
                    state_n   = skid_load ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    load       = skid_valid;
                    load_data  = skid_data;
                    skid_clear = 1'b1;
                    pc_n       = pc + 32'd4;
                    state_n    = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            squash <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            squash <= squash_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= 32'h0;
        end else if (redirect_valid || (!load && if_valid && !stall)) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
        end else if (load) begin
            if_valid <= 1'b1;
            if_instr <= load_data;
            if_pc    <= pc;
        end
    end

    fetch_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem_rdata),
        .valid (skid_valid),
        .dout  (skid_data)
    );
endmodule
